// File: rtl/tdm_demux_1to4_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4_pkg
// Shared constants for the 4-slot TDM receive demultiplexer.
//   - slot_t / SLOT_A..SLOT_D : slot index of a bit within a frame
//   - ST_HUNT / ST_LOCKED     : frame-alignment state encoding
//   - DEF_WORD_W / DEF_MISS_MAX : default parameter values
// -----------------------------------------------------------------------------
package tdm_demux_1to4_pkg;

    localparam int DEF_WORD_W   = 8;
    localparam int DEF_MISS_MAX = 2;
    localparam int NUM_CH       = 4;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_A = 2'd0;
    localparam slot_t SLOT_B = 2'd1;
    localparam slot_t SLOT_C = 2'd2;
    localparam slot_t SLOT_D = 2'd3;

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/tdm_word_shift.sv
// -----------------------------------------------------------------------------
// tdm_word_shift
// One channel's word assembler: MSB-first shift register plus a parallel
// output register with a one-cycle valid strobe.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : discard the partial word (takes priority over delivery)
//   i_shift      : shift i_din into the register this cycle
//   i_last       : the bit being shifted is the word's LSB
//   i_din        : serial data bit
//   o_word       : last complete word (held until the next delivery)
//   o_valid      : high for one cycle when o_word has just been updated
// -----------------------------------------------------------------------------
module tdm_word_shift #(
    parameter int WORD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic              i_last,
    input  logic              i_din,
    output logic [WORD_W-1:0] o_word,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_sr;
    logic [WORD_W-1:0] r_word;
    logic              r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr    <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_clear) begin
                // A clear with shift restarts the word with this bit as its MSB.
                r_sr <= i_shift ? WORD_W'(i_din) : '0;
            end else if (i_shift) begin
                if (i_last) begin
                    r_word  <= {r_sr[WORD_W-2:0], i_din};
                    r_valid <= 1'b1;
                    r_sr    <= '0;
                end else begin
                    r_sr <= {r_sr[WORD_W-2:0], i_din};
                end
            end
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;

endmodule

// File: rtl/tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4
// Receive side of a 4-slot TDM serial link. Aligns to i_fsync, routes each
// slot's bit to its channel and assembles WORD_W-bit words (MSB first, one bit
// per frame). A flywheel tolerates up to MISS_MAX-1 consecutive missing frame
// markers before dropping lock.
// Ports:
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_din              : serial TDM data
//   i_fsync            : frame marker, high with the slot-0 bit
//   o_a..o_d           : channel words
//   o_va..o_vd         : one-cycle "word updated" strobes
//   o_s                : slot index of the bit on i_din this cycle
//   o_lock             : frame aligned
//   o_err              : one-cycle strobe on misaligned marker or lock loss
// -----------------------------------------------------------------------------
module tdm_demux_1to4
    import tdm_demux_1to4_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int MISS_MAX = DEF_MISS_MAX
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_din,
    input  logic              i_fsync,
    output logic [WORD_W-1:0] o_a,
    output logic [WORD_W-1:0] o_b,
    output logic [WORD_W-1:0] o_c,
    output logic [WORD_W-1:0] o_d,
    output logic              o_va,
    output logic              o_vb,
    output logic              o_vc,
    output logic              o_vd,
    output logic [1:0]        o_s,
    output logic              o_lock,
    output logic              o_err
);

    localparam int              BW       = $clog2(WORD_W);
    localparam logic [BW-1:0]   LAST_BIT = BW'(WORD_W - 1);

    logic [0:0]    r_state;
    slot_t         r_slot;
    logic [BW-1:0] r_bit;
    logic [2:0]    r_miss;

    logic          w_locked;
    logic          w_capture;
    logic          w_realign;
    logic          w_miss;
    logic [2:0]    w_miss_inc;
    logic          w_drop;
    logic          w_start;
    logic          w_run;
    logic          w_last;

    logic [WORD_W-1:0] w_word [NUM_CH];
    logic [NUM_CH-1:0] w_valid;

    assign w_locked   = (r_state == ST_LOCKED);
    assign w_capture  = !w_locked && i_fsync;
    assign w_realign  = w_locked && i_fsync && (r_slot != SLOT_A);
    assign w_miss     = w_locked && !i_fsync && (r_slot == SLOT_A);
    // r_miss never exceeds MISS_MAX-1 (<= 6), so the 3-bit increment cannot wrap.
    assign w_miss_inc = r_miss + 3'd1;
    assign w_drop     = w_miss && (w_miss_inc == 3'(MISS_MAX));
    // Either marker event makes this bit channel A's MSB of a fresh word.
    assign w_start    = w_capture || w_realign;
    assign w_run      = w_locked && !w_realign && !w_drop;
    assign w_last     = (r_bit == LAST_BIT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_HUNT;
            r_slot  <= SLOT_A;
            r_bit   <= '0;
            r_miss  <= '0;
        end else if (w_start) begin
            r_state <= ST_LOCKED;
            r_slot  <= SLOT_B;
            r_bit   <= '0;
            r_miss  <= '0;
        end else if (w_drop) begin
            r_state <= ST_HUNT;
            r_slot  <= SLOT_A;
            r_bit   <= '0;
            r_miss  <= '0;
        end else if (w_locked) begin
            r_slot <= r_slot + 2'd1;
            if (r_slot == SLOT_D) begin
                r_bit <= w_last ? '0 : r_bit + 1'b1;
            end
            if (r_slot == SLOT_A) begin
                r_miss <= i_fsync ? 3'd0 : w_miss_inc;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam slot_t CH = slot_t'(gi);
            logic w_shift;

            assign w_shift = (w_start && (CH == SLOT_A)) || (w_run && (r_slot == CH));

            tdm_word_shift #(
                .WORD_W (WORD_W)
            ) u_shift (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_clear (w_start || w_drop),
                .i_shift (w_shift),
                .i_last  (w_last),
                .i_din   (i_din),
                .o_word  (w_word[gi]),
                .o_valid (w_valid[gi])
            );
        end
    endgenerate

    assign o_a    = w_word[0];
    assign o_b    = w_word[1];
    assign o_c    = w_word[2];
    assign o_d    = w_word[3];
    assign o_va   = w_valid[0];
    assign o_vb   = w_valid[1];
    assign o_vc   = w_valid[2];
    assign o_vd   = w_valid[3];
    // A marker in hunt or a realign forces slot A; otherwise the counter is the slot.
    assign o_s    = (w_locked && !i_fsync) ? r_slot : SLOT_A;
    assign o_lock = w_locked;
    assign o_err  = w_realign || w_drop;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
module tb_tdm_demux_1to4;

    localparam int W  = 8;
    localparam int MM = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         din = 1'b0;
    logic         fsync = 1'b0;
    logic [W-1:0] o_a, o_b, o_c, o_d;
    logic         o_va, o_vb, o_vc, o_vd;
    logic [1:0]   o_s;
    logic         o_lock, o_err;

    tdm_demux_1to4 #(.WORD_W(W), .MISS_MAX(MM)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_din   (din),
        .i_fsync (fsync),
        .o_a     (o_a),
        .o_b     (o_b),
        .o_c     (o_c),
        .o_d     (o_d),
        .o_va    (o_va),
        .o_vb    (o_vb),
        .o_vc    (o_vc),
        .o_vd    (o_vd),
        .o_s     (o_s),
        .o_lock  (o_lock),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    logic [W-1:0] obs_w [4];
    logic [3:0]   obs_v;
    assign obs_w[0] = o_a;
    assign obs_w[1] = o_b;
    assign obs_w[2] = o_c;
    assign obs_w[3] = o_d;
    assign obs_v    = {o_vd, o_vc, o_vb, o_va};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_cycle  = 0;

    // Reference model: bit position since alignment, per-channel accumulators.
    bit           m_locked;
    int           m_pos;
    int           m_miss;
    int           m_acc [4];
    int           m_cnt [4];
    logic [W-1:0] e_word [4];
    logic [3:0]   e_v;
    logic         e_lock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, n_cycle, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < 4; n++) begin
            m_acc[n] = 0;
            m_cnt[n] = 0;
        end
    endtask

    task automatic model_push(input int n, input logic d);
        m_acc[n] = m_acc[n] * 2 + int'(d);
        m_cnt[n] = m_cnt[n] + 1;
        if (m_cnt[n] == W) begin
            e_word[n] = W'(m_acc[n]);
            e_v[n]    = 1'b1;
            m_acc[n]  = 0;
            m_cnt[n]  = 0;
        end
    endtask

    task automatic check_regs();
        check("LOCK", 32'(o_lock), 32'(e_lock));
        for (int n = 0; n < 4; n++) begin
            check($sformatf("WORD%0d", n), 32'(obs_w[n]), 32'(e_word[n]));
            check($sformatf("VALID%0d", n), 32'(obs_v[n]), 32'(e_v[n]));
        end
    endtask

    task automatic step(input logic d, input logic f);
        int   slot;
        int   exp_s;
        logic exp_err;
        @(negedge clk);
        din   = d;
        fsync = f;
        #1;
        check_regs();
        e_v  = 4'b0;
        slot = m_pos % 4;
        if (!m_locked) begin
            exp_s   = 0;
            exp_err = 1'b0;
            if (f) begin
                model_clear();
                model_push(0, d);
                m_locked = 1'b1;
                m_pos    = 1;
                m_miss   = 0;
            end
        end else if (f && slot != 0) begin
            exp_s   = 0;
            exp_err = 1'b1;
            model_clear();
            model_push(0, d);
            m_pos  = 1;
            m_miss = 0;
        end else if (slot == 0 && !f && m_miss + 1 == MM) begin
            exp_s    = 0;
            exp_err  = 1'b1;
            model_clear();
            m_locked = 1'b0;
            m_pos    = 0;
            m_miss   = 0;
        end else begin
            exp_s   = slot;
            exp_err = 1'b0;
            if (slot == 0) m_miss = f ? 0 : m_miss + 1;
            model_push(slot, d);
            m_pos = (m_pos + 1) % 4;
        end
        check("S", 32'(o_s), 32'(exp_s));
        check("ERR", 32'(o_err), 32'(exp_err));
        e_lock = m_locked;
        n_cycle++;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        fsync = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_locked = 1'b0;
        m_pos    = 0;
        m_miss   = 0;
        model_clear();
        for (int n = 0; n < 4; n++) e_word[n] = '0;
        e_v    = 4'b0;
        e_lock = 1'b0;
        check_regs();
        check("S_RST", 32'(o_s), 32'd0);
        check("ERR_RST", 32'(o_err), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        n_cycle = 0;
    endtask

    // Sends the bits of one word per channel, starting at bit position 'start'.
    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d,
                             input int start, input int skip_frame);
        logic [W-1:0] w [4];
        int slot;
        int frame;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int i = start; i < 4 * W; i++) begin
            slot  = i % 4;
            frame = i / 4;
            step(w[slot][W-1-frame], (slot == 0) && (frame != skip_frame));
        end
    endtask

    initial begin
        int slot;
        logic f;
        do_reset();

        // No marker: stays hunting, S=0, no strobes.
        repeat (20) step(1'($urandom % 2), 1'b0);

        // Fresh lock: the first marker cycle becomes cycle 0 of the word.
        n_cycle = 0;
        send_word(8'hA5, 8'h3C, 8'hFF, 8'h00, 0, -1);

        // One missing marker in frame 3: flywheel keeps the word intact.
        send_word(8'h5A, 8'hC3, 8'h96, 8'h69, 0, 3);

        // Two missing markers: lock loss, then relock.
        repeat (8) step(1'($urandom % 2), 1'b0);
        send_word(8'h12, 8'h34, 8'h56, 8'h78, 0, -1);

        // Misaligned marker at slot 2 mid-word; partial words never strobe.
        for (int i = 0; i < 10; i++) step(1'($urandom % 2), (i % 4) == 0);
        step(1'b1, 1'b1);
        send_word(8'h81, 8'h7E, 8'h24, 8'hE7, 1, -1);

        // Reset mid-word.
        for (int i = 0; i < 13; i++) step(1'($urandom % 2), (i % 4) == 0);
        do_reset();
        repeat (3) step(1'($urandom % 2), 1'b0);
        send_word(8'hC5, 8'h0F, 8'hF0, 8'h99, 0, -1);

        // Randomized traffic with occasional missing and misplaced markers.
        repeat (800) begin
            slot = m_pos % 4;
            if (!m_locked)      f = 1'(($urandom % 3) == 0);
            else if (slot == 0) f = 1'(($urandom % 12) != 0);
            else                f = 1'(($urandom % 60) == 0);
            step(1'($urandom % 2), f);
        end
        step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
